// File: rtl/seg_display_scanner.sv
// Eight-digit common-anode hex display scanner for the CPU display word,
// with paused (dp) and halted (blink) status; `SEG_LZS_EN enables leading-zero suppression.
module seg_display_scanner #(
    parameter int unsigned ScanDiv     = 100000,
    parameter int unsigned BlinkFrames = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] display,
    input  logic        run,
    input  logic        halt,
    input  logic        freeze,
    output logic [7:0]  seg,
    output logic [7:0]  an
);

    localparam int unsigned CntW  = (ScanDiv > 1) ? $clog2(ScanDiv) : 1;
    localparam int unsigned FcntW = (BlinkFrames > 1) ? $clog2(BlinkFrames) : 1;
    localparam logic [CntW-1:0]  CntLast  = CntW'(ScanDiv - 1);
    localparam logic [FcntW-1:0] FcntLast = FcntW'(BlinkFrames - 1);

    logic [CntW-1:0]  cnt;
    logic [2:0]       idx;
    logic [31:0]      shadow;
    logic [FcntW-1:0] fcnt;
    logic             blank;

    logic             tick_c;
    logic             frame_c;
    logic [31:0]      upper_c;
    logic [3:0]       nib_c;
    logic             dark_c;
    logic [7:0]       seg_d;
    logic [7:0]       an_d;

    // Active-low {g,f,e,d,c,b,a} hex glyphs.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        s = 7'h7F;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign tick_c  = (cnt == CntLast);
    assign frame_c = tick_c && (idx == 3'd7);
    assign upper_c = shadow >> {idx, 2'b00};
    assign nib_c   = upper_c[3:0];

`ifdef SEG_LZS_EN
    assign dark_c = (idx != 3'd0) && (upper_c == 32'h0);
`else
    assign dark_c = 1'b0;
`endif

    // Next output pattern for the digit currently selected.
    always_comb begin
        an_d  = 8'hFF;
        seg_d = 8'hFF;
        if (!blank) begin
            an_d = ~(8'h01 << idx);
            if (!dark_c) begin
                seg_d = {~((idx == 3'd0) && !run), hex7(nib_c)};
            end
        end
    end

    // Prescaler, digit scan and frame-coherent shadow capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            idx    <= 3'd0;
            shadow <= 32'h0;
        end else begin
            cnt <= tick_c ? '0 : cnt + CntW'(1);
            if (tick_c) begin
                idx <= idx + 3'd1;
            end
            if (frame_c && !freeze) begin
                shadow <= display;
            end
        end
    end

    // Halt blink: blank toggles every BlinkFrames frames while halted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt  <= '0;
            blank <= 1'b0;
        end else if (!halt) begin
            fcnt  <= '0;
            blank <= 1'b0;
        end else if (frame_c) begin
            if (fcnt == FcntLast) begin
                fcnt  <= '0;
                blank <= ~blank;
            end else begin
                fcnt <= fcnt + FcntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= 8'hFF;
            an  <= 8'hFF;
        end else begin
            seg <= seg_d;
            an  <= an_d;
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner: directed steps plus random traffic
// compared against a cycle-count based reference model.
`timescale 1ns/1ps
module tb_seg_display_scanner;

    localparam int SCAN  = 4;
    localparam int BLINK = 2;
    localparam int FRAME = 8 * SCAN;

    logic        clk;
    logic        rst_n;
    logic [31:0] display;
    logic        run;
    logic        halt;
    logic        freeze;
    logic [7:0]  seg;
    logic [7:0]  an;

    int checks;
    int errors;

    // Reference model: cycles since reset, captured word, halted frame count.
    int          k;
    logic [31:0] m_shadow;
    int          m_hf;
    logic [6:0]  glyph [16];

    seg_display_scanner #(.ScanDiv(SCAN), .BlinkFrames(BLINK)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .display (display),
        .run     (run),
        .halt    (halt),
        .freeze  (freeze),
        .seg     (seg),
        .an      (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s at k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        k        = 0;
        m_shadow = 32'h0;
        m_hf     = 0;
    endtask

    // One clock: predict outputs from pre-edge model state, advance model, compare.
    task automatic step();
        int          d;
        logic        blank;
        logic [7:0]  es;
        logic [7:0]  ea;
        logic [31:0] upper;
        d     = (k / SCAN) % 8;
        blank = ((m_hf / BLINK) % 2) == 1;
        upper = m_shadow >> (4 * d);
        if (blank) begin
            es = 8'hFF;
            ea = 8'hFF;
        end else begin
            ea = 8'hFF ^ (8'(1) << d);
            es = {(d == 0 && !run) ? 1'b0 : 1'b1, glyph[upper[3:0]]};
`ifdef SEG_LZS_EN
            if (d >= 1 && upper == 32'h0) es = 8'hFF;
`endif
        end
        if ((k % FRAME) == FRAME - 1) begin
            if (!freeze) m_shadow = display;
            if (halt) m_hf++;
        end
        if (!halt) m_hf = 0;
        k++;
        @(posedge clk);
        #1;
        check("seg", seg, es);
        check("an", an, ea);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        display = 32'h0;
        run     = 1'b1;
        halt    = 1'b0;
        freeze  = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset_seg", seg, 8'hFF);
        check("reset_an", an, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero display scans all digits and wraps.
        steps(40);

        // Mid-frame update must not disturb the current frame.
        display = 32'h89ABCDEF;
        steps(2 * FRAME);

        // Freeze across a boundary holds the old word.
        freeze  = 1'b1;
        display = 32'h12345678;
        steps(FRAME + 5);
        freeze = 1'b0;
        steps(2 * FRAME);

        // Paused: decimal point on digit 0 only.
        run = 1'b0;
        steps(FRAME + 3);
        run = 1'b1;

        // Halted blink, then release mid-frame.
        halt = 1'b1;
        steps(9 * FRAME + 7);
        halt = 1'b0;
        steps(FRAME);

        // Leading zeros.
        display = 32'h00000A05;
        steps(3 * FRAME);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(7) == 0) begin
                case ($urandom_range(3))
                    0: display = $urandom;
                    1: display = $urandom >> (4 * $urandom_range(7));
                    2: display = 32'h0;
                    default: display = 32'hFFFF_FFFF;
                endcase
            end
            if ($urandom_range(15) == 0) freeze = ~freeze;
            if ($urandom_range(9) == 0) run = ~run;
            if ($urandom_range(99) == 0) halt = ~halt;
            step();
        end

        // Asynchronous reset in the middle of a frame.
        halt    = 1'b0;
        freeze  = 1'b0;
        run     = 1'b1;
        display = 32'hC0FFEE42;
        steps(FRAME + 9);
        rst_n = 1'b0;
        #1;
        check("async_rst_seg", seg, 8'hFF);
        check("async_rst_an", an, 8'hFF);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        steps(3 * FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
